usb_uart_tx_agg: RTL
====================

USB_UART_TX_AGG -- requirements
Module: usb_uart_tx_agg

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, FIFO depth = 2**DEPTH_LOG2 bytes (64).
REQ-002 SHALL have parameter THRESH, default 32, level at which draining starts immediately (1..depth).
REQ-003 SHALL have parameter TIMEOUT, default 48000, idle cycles after the last accepted write before draining starts (1 ms at 48 MHz; 1..65535).
REQ-004 clk_48mhz  in  1  sole clock; all state on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_data  in  8  byte from the application.
REQ-007 wr_valid  in  1  wr_data valid.
REQ-008 wr_ready  out  1  FIFO can accept a byte.
REQ-009 flush  in  1  single-cycle request to drain now, regardless of level or timer.
REQ-010 uart_in_data  out  8  byte to the USB CDC core.
REQ-011 uart_in_valid  out  1  uart_in_data valid.
REQ-012 uart_in_ready  in  1  CDC core accepts the byte.
REQ-013 level  out  DEPTH_LOG2+1  bytes currently stored.

Function
REQ-014 A write SHALL be accepted in a cycle where wr_valid && wr_ready; a read SHALL be accepted in a cycle where uart_in_valid && uart_in_ready.
REQ-015 wr_ready SHALL be !full, with full meaning level == 2**DEPTH_LOG2; a write is never dropped.
REQ-016 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap from depth-1 to 0; byte order SHALL be preserved.
REQ-017 level SHALL be incremented by an accepted write, decremented by an accepted read, and left unchanged when both occur in the same cycle.
REQ-018 uart_in_data SHALL show the byte at the read pointer (first-word fall-through) whenever uart_in_valid is 1.
REQ-019 uart_in_data SHALL hold stable while uart_in_valid && !uart_in_ready.
REQ-020 The FSM SHALL have three states: IDLE (empty), HOLD (non-empty, collecting), and DRAIN (presenting bytes).
REQ-021 uart_in_valid SHALL be 1 only in DRAIN with level != 0.
REQ-022 The next state SHALL be computed from next_level, the level value after the current cycle's update:
  - IDLE -> HOLD if next_level != 0; IDLE -> DRAIN instead if next_level >= THRESH or flush is high with next_level != 0.
  - HOLD -> DRAIN if next_level >= THRESH, or the timer is at TIMEOUT-1 and no write is accepted, or flush.
  - DRAIN -> IDLE if next_level == 0; otherwise it stays in DRAIN (writes arriving during DRAIN are drained too).
REQ-023 Timer: a 16-bit counter.
  - Cleared in IDLE, in DRAIN, and on any accepted write.
  - Otherwise incremented in HOLD.
  - Saturates at TIMEOUT-1.
REQ-024 A flush seen in IDLE with next_level == 0 SHALL be ignored, with no state change.
REQ-025 Latency: with THRESH=1, a write accepted in cycle N into an empty FIFO SHALL give uart_in_valid=1 in cycle N+1.
REQ-026 Full with a simultaneous read: wr_ready SHALL remain 0 in that cycle, because wr_ready depends on the registered level only.
REQ-027 There SHALL be no combinational path from uart_in_ready to wr_ready or uart_in_valid.

Reset
REQ-028 While reset_n=0, the following SHALL hold asynchronously:
  - state = IDLE, pointers = 0, level = 0, timer = 0.
  - uart_in_valid = 0, wr_ready = 0.
REQ-029 After reset_n deasserts, wr_ready SHALL be 1 from the first clock edge onward; FIFO contents are don't-care.
REQ-030 Reset asserted mid-drain SHALL discard all stored bytes, and no stale byte SHALL be presented afterwards.

Verification
REQ-031 THRESH=4, write 0x41,0x42,0x43,0x44 back-to-back with uart_in_ready=1 -> uart_in_valid rises the cycle after 0x44 is accepted; bytes come out in order; level returns to 0; state IDLE.
REQ-032 TIMEOUT=10, write one byte 0x55, no further writes -> uart_in_valid stays 0 for 10 cycles, then presents 0x55; a second write mid-count restarts the 10-cycle wait.
REQ-033 Fill 64 bytes with uart_in_ready=0 -> wr_ready=0 and level=64 after the 64th write; then uart_in_ready=1 with wr_valid=1 -> level never exceeds 64 and all 64+N bytes arrive in order across the pointer wrap.
REQ-034 3 bytes in HOLD plus a 1-cycle flush -> DRAIN the next cycle, 3 bytes delivered; flush while IDLE and empty -> no uart_in_valid.
REQ-035 Backpressure: in DRAIN, toggle uart_in_ready randomly -> uart_in_data is stable whenever valid && !ready, with no loss or duplication.
REQ-036 reset_n pulsed low mid-drain with 10 bytes stored -> uart_in_valid=0 and level=0 immediately; no old byte appears after release.

Source files
------------

// File: rtl/usb_uart_tx_agg.sv
// Byte aggregator between an application and a USB CDC IN endpoint: buffers bytes
// in a circular FIFO and releases them in bursts on threshold, idle timeout or flush.
module usb_uart_tx_agg #(
  parameter int DEPTH_LOG2 = 6,
  parameter int THRESH     = 32,
  parameter int TIMEOUT    = 48000
) (
  input  logic                  clk_48mhz,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  flush,
  output logic [7:0]            uart_in_data,
  output logic                  uart_in_valid,
  input  logic                  uart_in_ready,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam int                LW         = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]     FULL_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0]     THRESH_LVL = LW'(THRESH);
  localparam logic [LW-1:0]     LVL_ONE    = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [15:0]       TIMER_MAX  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [15:0]           timer_q, timer_d;
  logic                  ready_en_q;
  logic [7:0]            mem [DEPTH];
  logic                  wr_fire;
  logic                  rd_fire;

  // Outputs depend only on registered state, so uart_in_ready never reaches them.
  assign wr_ready      = ready_en_q && (level_q != FULL_LVL);
  assign uart_in_valid = (state_q == DRAIN) && (level_q != '0);
  assign uart_in_data  = mem[rd_ptr_q];
  assign level         = level_q;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = uart_in_valid && uart_in_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    timer_d  = '0;

    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (wr_fire && !rd_fire)      level_d = level_q + LVL_ONE;
    else if (!wr_fire && rd_fire) level_d = level_q - LVL_ONE;

    if (state_q == HOLD && !wr_fire) begin
      timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (level_d != '0) begin
          state_d = (level_d >= THRESH_LVL || flush) ? DRAIN : HOLD;
        end
      end
      HOLD: begin
        if (level_d >= THRESH_LVL || flush || (timer_q == TIMER_MAX && !wr_fire)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (level_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      timer_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      ready_en_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; zeroed pointers and level make old bytes unreachable.
  always_ff @(posedge clk_48mhz) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

endmodule
